// File: rtl/msu_pkg.sv
`default_nettype none
// ============================================================================
// msu_pkg : shared state encoding, error-bit indices and beat-count helpers
// Rev 1.0
// ============================================================================
package msu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } msu_state_e;

  localparam int ERR_SIZE = 0;
  localparam int ERR_KEEP = 1;
  localparam int ERR_TCHK = 2;
  localparam int ERR_W    = 3;

  function automatic int axi_out_count(input int t_len, input int sq_bits, input int axi_len);
    return (t_len / axi_len) + (sq_bits / axi_len);
  endfunction

  function automatic int axi_bytes_per_txn(input int beats, input int axi_len);
    return (beats * axi_len) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msu_result_unpack_if.sv
`default_nettype none
// ============================================================================
// msu_result_unpack_if : MSU output stream plus result valid/ready handshake
// Rev 1.0
// ============================================================================
interface msu_result_unpack_if
  import msu_pkg::*;
#(
  parameter int AXI_LEN     = 32,
  parameter int T_LEN       = 64,
  parameter int SQ_OUT_BITS = 1024
);
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [AXI_LEN-1:0]       s_axis_tdata;
  logic [AXI_LEN/8-1:0]     s_axis_tkeep;
  logic                     res_valid;
  logic                     res_ready;
  logic [T_LEN-1:0]         res_t;
  logic [SQ_OUT_BITS-1:0]   res_sq;
  logic [ERR_W-1:0]         res_err;

  // master: stream producer and result consumer
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, res_ready,
    input  s_axis_tready, res_valid, res_t, res_sq, res_err
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, res_ready,
    output s_axis_tready, res_valid, res_t, res_sq, res_err
  );
endinterface
`default_nettype wire

// File: rtl/msu_axis_deser.sv
`default_nettype none
// ============================================================================
// msu_axis_deser : LSW-first shift-in deserialiser with beat counter
// Rev 1.0
// ============================================================================
module msu_axis_deser #(
  parameter int WIDTH = 32,
  parameter int BEATS = 6
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  input  wire logic                     clear,
  input  wire logic                     shift_en,
  input  wire logic [WIDTH-1:0]         din,
  output logic      [WIDTH*BEATS-1:0]   data_next,
  output logic                          done
);
  localparam int BUF_W = WIDTH * BEATS;
  localparam int CNT_W = $clog2(BEATS + 1);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_count;

  // data_next is the buffer as it will look once the current beat is taken
  generate
    if (BEATS > 1) begin : g_multi
      assign data_next = {din, r_buf[BUF_W-1:WIDTH]};
    end else begin : g_single
      assign data_next = din;
    end
  endgenerate

  assign done = shift_en && (r_count == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_count <= '0;
    end else begin
      if (shift_en) begin
        r_buf <= data_next;
      end
      if (clear) begin
        r_count <= '0;
      end else if (shift_en) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/msu_result_unpack.sv
`default_nettype none
// ============================================================================
// msu_result_unpack : collects one MSU result frame and presents it to the host
// Optional t-check build macro: MSU_RESULT_TCHECK_EN            Rev 1.0
// ============================================================================
module msu_result_unpack
  import msu_pkg::*;
#(
  parameter int AXI_LEN           = 32,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int T_LEN             = 64,
  parameter int SQ_OUT_BITS       = 1024
) (
  input  wire logic                          clk,
  input  wire logic                          reset_n,
  input  wire logic                          start_xfer,
  input  wire logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_in_bytes,
  input  wire logic [T_LEN-1:0]              exp_t_final,
  output logic                               busy,
  msu_result_unpack_if.slave                 bus
);
  localparam int AXI_OUT_COUNT = axi_out_count(T_LEN, SQ_OUT_BITS, AXI_LEN);
  localparam int BUF_W         = AXI_OUT_COUNT * AXI_LEN;
  localparam logic [C_XFER_SIZE_WIDTH-1:0] XFER_BYTES =
      C_XFER_SIZE_WIDTH'(axi_bytes_per_txn(AXI_OUT_COUNT, AXI_LEN));

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_COLLECT = COLLECT;
  localparam logic [1:0] S_PRESENT = PRESENT;

  logic [1:0]             r_state;
  logic                   w_arm;
  logic                   w_shift;
  logic                   w_done;
  logic                   w_tchk;
  logic [BUF_W-1:0]       w_buf_next;
  logic [ERR_W-1:0]       r_err;
  logic [T_LEN-1:0]       r_res_t;
  logic [SQ_OUT_BITS-1:0] r_res_sq;

  assign w_shift = bus.s_axis_tvalid && (r_state == S_COLLECT);
  assign w_arm   = start_xfer &&
                   ((r_state == S_IDLE) || ((r_state == S_PRESENT) && bus.res_ready));

  msu_axis_deser #(
    .WIDTH (AXI_LEN),
    .BEATS (AXI_OUT_COUNT)
  ) u_deser (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (w_arm),
    .shift_en  (w_shift),
    .din       (bus.s_axis_tdata),
    .data_next (w_buf_next),
    .done      (w_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (start_xfer) r_state <= S_COLLECT;
        S_COLLECT: if (w_done) r_state <= S_PRESENT;
        S_PRESENT: if (bus.res_ready) r_state <= start_xfer ? S_COLLECT : S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MSU_RESULT_TCHECK_EN
  logic [T_LEN-1:0] r_exp_t;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_exp_t <= '0;
    end else if (w_arm) begin
      r_exp_t <= exp_t_final;
    end
  end

  // evaluated against the incoming buffer so the flag is ready on PRESENT entry
  assign w_tchk = (w_buf_next[T_LEN-1:0] != r_exp_t);
`else
  logic unused_exp_t;
  assign unused_exp_t = ^exp_t_final;
  assign w_tchk       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err <= '0;
    end else if (w_arm) begin
      r_err           <= '0;
      r_err[ERR_SIZE] <= (xfer_size_in_bytes != XFER_BYTES);
    end else if (w_shift) begin
      if (bus.s_axis_tkeep != '1) begin
        r_err[ERR_KEEP] <= 1'b1;
      end
      if (w_done) begin
        r_err[ERR_TCHK] <= w_tchk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_res_t  <= '0;
      r_res_sq <= '0;
    end else if (w_done) begin
      r_res_t  <= w_buf_next[T_LEN-1:0];
      r_res_sq <= w_buf_next[T_LEN +: SQ_OUT_BITS];
    end
  end

  assign bus.s_axis_tready = (r_state == S_COLLECT);
  assign bus.res_valid     = (r_state == S_PRESENT);
  assign bus.res_t         = r_res_t;
  assign bus.res_sq        = r_res_sq;
  assign bus.res_err       = r_err;
  assign busy              = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_msu_result_unpack.sv
`default_nettype none
// ============================================================================
// tb_msu_result_unpack : directed self-checking bench, 6-beat / 24-byte frames
// Rev 1.0
// ============================================================================
module tb_msu_result_unpack;
  localparam logic [2:0] ERR_NONE = 3'b000;
`ifdef MSU_RESULT_TCHECK_EN
  localparam logic [2:0] ERR_T = 3'b100;
`else
  localparam logic [2:0] ERR_T = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_xfer = 1'b0;
  logic [31:0] xfer_size = '0;
  logic [63:0] exp_t = '0;
  logic        busy;
  int          n_cmp = 0;
  int          n_fail = 0;

  msu_result_unpack_if #(.AXI_LEN(32), .T_LEN(64), .SQ_OUT_BITS(128)) bus ();

  msu_result_unpack #(
    .AXI_LEN(32), .C_XFER_SIZE_WIDTH(32), .T_LEN(64), .SQ_OUT_BITS(128)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start_xfer         (start_xfer),
    .xfer_size_in_bytes (xfer_size),
    .exp_t_final        (exp_t),
    .busy               (busy),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [31:0] size, input logic [63:0] e);
    start_xfer = 1'b1;
    xfer_size  = size;
    exp_t      = e;
    tick();
    start_xfer = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k);
    int w = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    while (!bus.s_axis_tready && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) check("tready_timeout", 128'(bus.s_axis_tready), 128'd1);
    check("valid_early", 128'(bus.res_valid), 128'd0);
    tick();
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [63:0] t,
                              input logic [127:0] sq, input logic [2:0] err);
    check({tag, "_valid"}, 128'(bus.res_valid), 128'd1);
    check({tag, "_t"},     128'(bus.res_t), 128'(t));
    check({tag, "_sq"},    bus.res_sq, sq);
    check({tag, "_err"},   128'(bus.res_err), 128'(err));
    check({tag, "_tready"}, 128'(bus.s_axis_tready), 128'd0);
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = 4'hF;
    bus.res_ready     = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_tready", 128'(bus.s_axis_tready), 128'd0);
    check("rst_valid",  128'(bus.res_valid), 128'd0);
    check("rst_busy",   128'(busy), 128'd0);
    check("rst_err",    128'(bus.res_err), 128'd0);
    check("rst_t",      128'(bus.res_t), 128'd0);
    check("rst_sq",     bus.res_sq, 128'd0);
    reset_n = 1'b1;
    tick();
    check("idle_tready", 128'(bus.s_axis_tready), 128'd0);

    // 1. basic transfer
    arm(32'd24, 64'd5);
    check("t1_busy",   128'(busy), 128'd1);
    check("t1_tready", 128'(bus.s_axis_tready), 128'd1);
    beat(32'h5, 4'hF); beat(32'h0, 4'hF); beat(32'hA, 4'hF);
    beat(32'hB, 4'hF); beat(32'hC, 4'hF); beat(32'hD, 4'hF);
    check_result("t1", 64'd5, 128'h0000000D_0000000C_0000000B_0000000A, ERR_NONE);
    consume();
    check("t1_done_valid", 128'(bus.res_valid), 128'd0);
    check("t1_done_busy",  128'(busy), 128'd0);

    // 2. backpressure; a stray start_xfer mid-collect must not restart the count
    arm(32'd24, 64'd5);
    tick(); beat(32'h5, 4'hF);
    tick(); beat(32'h0, 4'hF);
    tick(); beat(32'hA, 4'hF);
    start_xfer = 1'b1; tick(); start_xfer = 1'b0;
    beat(32'hB, 4'hF);
    tick(); beat(32'hC, 4'hF);
    tick(); beat(32'hD, 4'hF);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) start_xfer = 1'b1;
      check("t2_hold_tready", 128'(bus.s_axis_tready), 128'd0);
      check("t2_hold_valid",  128'(bus.res_valid), 128'd1);
      tick();
      start_xfer = 1'b0;
    end
    check_result("t2", 64'd5, 128'h0000000D_0000000C_0000000B_0000000A, ERR_NONE);
    consume();
    check("t2_done_busy", 128'(busy), 128'd0);

    // 3. advertised size mismatch still collects six beats
    arm(32'd20, 64'd5);
    beat(32'h5, 4'hF); beat(32'h0, 4'hF); beat(32'h1, 4'hF);
    beat(32'h2, 4'hF); beat(32'h3, 4'hF);
    check("t3_five_tready", 128'(bus.s_axis_tready), 128'd1);
    beat(32'h4, 4'hF);
    check_result("t3", 64'd5, 128'h00000004_00000003_00000002_00000001, 3'b001);
    consume();

    // 4. final t differs from the expected value
    arm(32'd24, 64'd7);
    beat(32'h5, 4'hF); beat(32'h0, 4'hF); beat(32'h1, 4'hF);
    beat(32'h2, 4'hF); beat(32'h3, 4'hF); beat(32'h4, 4'hF);
    check_result("t4", 64'd5, 128'h00000004_00000003_00000002_00000001, ERR_T);
    consume();

    // 5. reset mid-transfer, then a fresh frame
    arm(32'd24, 64'd9);
    beat(32'h11, 4'hF); beat(32'h22, 4'hF); beat(32'h33, 4'hF);
    reset_n = 1'b0;
    tick(); tick();
    check("t5_rst_valid",  128'(bus.res_valid), 128'd0);
    check("t5_rst_tready", 128'(bus.s_axis_tready), 128'd0);
    check("t5_rst_busy",   128'(busy), 128'd0);
    check("t5_rst_t",      128'(bus.res_t), 128'd0);
    check("t5_rst_sq",     bus.res_sq, 128'd0);
    reset_n = 1'b1;
    tick();
    check("t5_idle_valid", 128'(bus.res_valid), 128'd0);
    arm(32'd24, 64'd9);
    beat(32'h9, 4'hF); beat(32'h0, 4'hF); beat(32'h91, 4'hF);
    beat(32'h92, 4'hF); beat(32'h93, 4'hF); beat(32'h94, 4'hF);
    check_result("t5", 64'd9, 128'h00000094_00000093_00000092_00000091, ERR_NONE);

    // 6. consume and re-arm in the same cycle; one partial-keep beat
    bus.res_ready = 1'b1;
    start_xfer    = 1'b1;
    xfer_size     = 32'd24;
    exp_t         = 64'd2;
    tick();
    bus.res_ready = 1'b0;
    start_xfer    = 1'b0;
    check("t6_rearm_busy",   128'(busy), 128'd1);
    check("t6_rearm_tready", 128'(bus.s_axis_tready), 128'd1);
    check("t6_rearm_valid",  128'(bus.res_valid), 128'd0);
    beat(32'h2, 4'hF); beat(32'h0, 4'hF); beat(32'hA1, 4'hF);
    beat(32'hA2, 4'hE); beat(32'hA3, 4'hF); beat(32'hA4, 4'hF);
    check_result("t6", 64'd2, 128'h000000A4_000000A3_000000A2_000000A1, 3'b010);
    consume();
    check("t6_done_busy", 128'(busy), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
